// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one burst memory port between the icache line fill,
// the dcache line fill and the dcache write-through path. Writes take
// priority and are echoed to the icache as a one-cycle snoop.
// Optional build macro: L1_ARB_ROUND_ROBIN_EN (IC/DC round robin instead of
// fixed DC-over-IC priority).
module l1_mem_arbiter #(
  parameter int unsigned LINESIZE = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IC_REQ,
  input  logic [31:0] IC_ADDR,
  output logic        IC_DONE,
  output logic [31:0] IC_DATA,
  input  logic        DC_REQ,
  input  logic [31:0] DC_ADDR,
  output logic        DC_DONE,
  output logic [31:0] DC_DATA,
  input  logic        WR_REQ,
  input  logic [31:0] WR_ADDR,
  input  logic [31:0] WR_DATA,
  input  logic [3:0]  WR_BE,
  output logic        WR_ACK,
  output logic [31:0] MEM_ADDR,
  output logic [4:0]  MEM_BURST,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  input  logic        MEM_WAIT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic [25:0] SNOOP_ADDR,
  output logic [31:0] SNOOP_DATA,
  output logic [3:0]  SNOOP_BE,
  output logic        SNOOP_WE
);

  localparam int unsigned CNT_W     = $clog2(LINESIZE);
  localparam int unsigned OFF_W     = CNT_W + 2;
  localparam logic [31:0] LINE_MASK = ~32'((1 << OFF_W) - 1);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [4:0]  BURST_LEN = 5'(LINESIZE);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINESIZE - 1);

  typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD, RD_DATA} state_t;

  state_t            state_q, state_d;
  logic              own_dc_q, own_dc_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pick_dc;

  logic              ic_done_d, dc_done_d, wr_ack_d, snoop_we_d;
  logic [31:0]       ic_data_d, dc_data_d, snoop_data_d;
  logic [25:0]       snoop_addr_d;
  logic [3:0]        snoop_be_d;
  logic              mem_rd_d, mem_wr_d;
  logic [31:0]       mem_addr_d, mem_wdata_d;
  logic [4:0]        mem_burst_d;
  logic [3:0]        mem_be_d;

`ifdef L1_ARB_ROUND_ROBIN_EN
  logic              rr_ic_q, rr_ic_d;
`endif

  // State, grant latches and all registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      own_dc_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cnt_q      <= '0;
      IC_DONE    <= 1'b0;
      IC_DATA    <= '0;
      DC_DONE    <= 1'b0;
      DC_DATA    <= '0;
      WR_ACK     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_BURST  <= '0;
      MEM_RD     <= 1'b0;
      MEM_WR     <= 1'b0;
      MEM_WDATA  <= '0;
      MEM_BE     <= '0;
      SNOOP_ADDR <= '0;
      SNOOP_DATA <= '0;
      SNOOP_BE   <= '0;
      SNOOP_WE   <= 1'b0;
`ifdef L1_ARB_ROUND_ROBIN_EN
      rr_ic_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      own_dc_q   <= own_dc_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      IC_DONE    <= ic_done_d;
      IC_DATA    <= ic_data_d;
      DC_DONE    <= dc_done_d;
      DC_DATA    <= dc_data_d;
      WR_ACK     <= wr_ack_d;
      MEM_ADDR   <= mem_addr_d;
      MEM_BURST  <= mem_burst_d;
      MEM_RD     <= mem_rd_d;
      MEM_WR     <= mem_wr_d;
      MEM_WDATA  <= mem_wdata_d;
      MEM_BE     <= mem_be_d;
      SNOOP_ADDR <= snoop_addr_d;
      SNOOP_DATA <= snoop_data_d;
      SNOOP_BE   <= snoop_be_d;
      SNOOP_WE   <= snoop_we_d;
`ifdef L1_ARB_ROUND_ROBIN_EN
      rr_ic_q    <= rr_ic_d;
`endif
    end
  end

  // Next state, arbitration, beat steering and next output values
  always_comb begin
    state_d      = state_q;
    own_dc_d     = own_dc_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    cnt_d        = cnt_q;
    ic_done_d    = 1'b0;
    dc_done_d    = 1'b0;
    ic_data_d    = IC_DATA;
    dc_data_d    = DC_DATA;
    wr_ack_d     = 1'b0;
    snoop_we_d   = 1'b0;
    snoop_addr_d = SNOOP_ADDR;
    snoop_data_d = SNOOP_DATA;
    snoop_be_d   = SNOOP_BE;
`ifdef L1_ARB_ROUND_ROBIN_EN
    rr_ic_d      = rr_ic_q;
    pick_dc      = DC_REQ && (!IC_REQ || !rr_ic_q);
`else
    pick_dc      = DC_REQ;
`endif

    unique case (state_q)
      IDLE: begin
        // WR_ACK still high means the acknowledged request has not dropped yet
        if (WR_REQ && !WR_ACK) begin
          state_d = WR_CMD;
          addr_d  = WR_ADDR & WORD_MASK;
          wdata_d = WR_DATA;
          be_d    = WR_BE;
        end else if (IC_REQ || DC_REQ) begin
          state_d  = RD_CMD;
          own_dc_d = pick_dc;
          addr_d   = (pick_dc ? DC_ADDR : IC_ADDR) & LINE_MASK;
          cnt_d    = '0;
`ifdef L1_ARB_ROUND_ROBIN_EN
          rr_ic_d  = pick_dc;
`endif
        end
      end
      WR_CMD: begin
        if (!MEM_WAIT) begin
          state_d      = IDLE;
          wr_ack_d     = 1'b1;
          snoop_we_d   = 1'b1;
          snoop_addr_d = addr_q[27:2];
          snoop_data_d = wdata_q;
          snoop_be_d   = be_q;
        end
      end
      RD_CMD: begin
        if (!MEM_WAIT) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (MEM_RVALID) begin
          if (own_dc_q) begin
            dc_done_d = 1'b1;
            dc_data_d = MEM_RDATA;
          end else begin
            ic_done_d = 1'b1;
            ic_data_d = MEM_RDATA;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_rd_d    = (state_d == RD_CMD);
    mem_wr_d    = (state_d == WR_CMD);
    mem_addr_d  = (mem_rd_d || mem_wr_d) ? addr_d : '0;
    mem_burst_d = mem_rd_d ? BURST_LEN : (mem_wr_d ? 5'd1 : 5'd0);
    mem_wdata_d = mem_wr_d ? wdata_d : '0;
    mem_be_d    = mem_wr_d ? be_d : '0;
  end

endmodule
